slice_sched: RTL and testbench

Sequencer for the Viterbi input slicer. It accepts 276-bit received-data frames from the PS-side source over a valid/ready handshake and double-buffers them (active plus shadow). It then steps a bit pointer down each active frame at 4 bits/cycle (`CODE_RATE_2`) or 6 bits/cycle (`CODE_RATE_3`), under downstream backpressure. It drives the slicer's enable, frame and pointer, and generates end-of-data and completion.

---
 rtl/slice_sched.sv | 203 ++++++++++++++++++++
 tb/tb_slice_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_sched.sv
// slice_sched: double-buffered frame sequencer that walks a slice pointer down each frame for the Viterbi slicer.
// Define SLICE_SCHED_STARVE_CNT_EN to add o_starve_cnt, a saturating count of starved RUN cycles.
module slice_sched #(
  parameter int FRAME_W   = 276,
  parameter int PTR_W     = 9,
  parameter int DRAIN_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_code_rate,
  input  logic               i_frame_valid,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic               i_last_frame,
  output logic               o_frame_ready,
  input  logic               i_dec_ready,
  output logic               o_en_s,
  output logic [FRAME_W-1:0] o_frame,
  output logic [PTR_W-1:0]   o_ptr,
  output logic               o_ood,
  output logic               o_busy,
  output logic               o_done
`ifdef SLICE_SCHED_STARVE_CNT_EN
  ,
  output logic [15:0]        o_starve_cnt
`endif
);

  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(FRAME_W - 1);
  localparam logic [PTR_W-1:0] STEP_R2 = PTR_W'(4);
  localparam logic [PTR_W-1:0] STEP_R3 = PTR_W'(6);
  localparam logic [PTR_W-1:0] LAST_R2 = PTR_W'(3);
  localparam logic [PTR_W-1:0] LAST_R3 = PTR_W'(5);

  localparam int                DCNT_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_t;

  state_t              state;
  logic [FRAME_W-1:0]  act_frame;
  logic [FRAME_W-1:0]  shd_frame;
  logic                act_full;
  logic                act_last;
  logic                shd_full;
  logic                shd_last;
  logic                last_acc;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    step_q;
  logic [PTR_W-1:0]    last_ptr_q;
  logic [DCNT_W-1:0]   drain_cnt;

  logic                accept;
  logic                final_slice;
  logic                release_act;

  // Only one frame may wait behind the active one, and nothing follows the final frame of a run.
  assign o_frame_ready = ((state == LOAD) || (state == RUN)) && !shd_full && !last_acc;
  assign accept        = i_frame_valid && o_frame_ready;

  assign o_en_s        = (state == RUN) && act_full && i_dec_ready;
  assign final_slice   = (ptr_q == last_ptr_q);
  assign release_act   = o_en_s && final_slice;
  assign o_ood         = release_act && act_last;

  assign o_frame       = act_frame;
  assign o_ptr         = ptr_q;
  assign o_busy        = (state != IDLE);
  assign o_done        = (state == DRAIN) && (drain_cnt == DCNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      act_frame  <= '0;
      shd_frame  <= '0;
      act_full   <= 1'b0;
      act_last   <= 1'b0;
      shd_full   <= 1'b0;
      shd_last   <= 1'b0;
      last_acc   <= 1'b0;
      ptr_q      <= PTR_TOP;
      step_q     <= STEP_R2;
      last_ptr_q <= LAST_R2;
      drain_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= LOAD;
            act_frame <= '0;
            shd_frame <= '0;
            act_full  <= 1'b0;
            act_last  <= 1'b0;
            shd_full  <= 1'b0;
            shd_last  <= 1'b0;
            last_acc  <= 1'b0;
            ptr_q     <= PTR_TOP;
            drain_cnt <= '0;
            case (i_code_rate)
              CODE_RATE_2: begin
                step_q     <= STEP_R2;
                last_ptr_q <= LAST_R2;
              end
              CODE_RATE_3: begin
                step_q     <= STEP_R3;
                last_ptr_q <= LAST_R3;
              end
              default: begin
                step_q     <= STEP_R2;
                last_ptr_q <= LAST_R2;
              end
            endcase
          end
        end

        LOAD: begin
          if (accept) begin
            state     <= RUN;
            act_frame <= i_frame;
            act_full  <= 1'b1;
            act_last  <= i_last_frame;
            last_acc  <= i_last_frame;
            ptr_q     <= PTR_TOP;
          end
        end

        RUN: begin
          if (accept && i_last_frame) begin
            last_acc <= 1'b1;
          end
          if (release_act) begin
            ptr_q <= PTR_TOP;
            if (act_last) begin
              state     <= DRAIN;
              act_full  <= 1'b0;
              drain_cnt <= '0;
            end else if (shd_full) begin
              act_frame <= shd_frame;
              act_last  <= shd_last;
              shd_full  <= 1'b0;
              shd_last  <= 1'b0;
            end else if (accept) begin
              // A frame arriving on the release edge bypasses the shadow so the slicer sees no bubble.
              act_frame <= i_frame;
              act_last  <= i_last_frame;
            end else begin
              act_full <= 1'b0;
              act_last <= 1'b0;
            end
          end else begin
            if (o_en_s) begin
              ptr_q <= ptr_q - step_q;
            end
            if (accept) begin
              if (!act_full) begin
                act_frame <= i_frame;
                act_full  <= 1'b1;
                act_last  <= i_last_frame;
                ptr_q     <= PTR_TOP;
              end else begin
                shd_frame <= i_frame;
                shd_full  <= 1'b1;
                shd_last  <= i_last_frame;
              end
            end
          end
        end

        DRAIN: begin
          if (drain_cnt == DCNT_LAST) begin
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + DCNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef SLICE_SCHED_STARVE_CNT_EN
  // An empty active buffer in RUN always means the run has not ended, since the last release leaves RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_starve_cnt <= '0;
    end else if ((state == IDLE) && i_start) begin
      o_starve_cnt <= '0;
    end else if ((state == RUN) && !act_full && (o_starve_cnt != 16'hFFFF)) begin
      o_starve_cnt <= o_starve_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_slice_sched.sv
// tb_slice_sched: scenario table plus a slice scoreboard for slice_sched.
// Also exercises o_starve_cnt when SLICE_SCHED_STARVE_CNT_EN is defined.
`timescale 1ns/1ps
module tb_slice_sched;

  localparam int FRAME_W   = 276;
  localparam int PTR_W     = 9;
  localparam int DRAIN_CYC = 2;
  localparam int TMO       = 3000;
  localparam int M_B2B     = 0;
  localparam int M_GAP     = 1;
  localparam int M_SAME    = 2;

  typedef struct {
    logic [PTR_W-1:0]   ptr;
    logic [FRAME_W-1:0] frame;
    logic               ood;
  } slice_t;

  typedef struct {
    logic rate;
    int   nframes;
    int   mode;
    int   gap;
    int   bp_ptr;
    int   bp_len;
    int   poke_ptr;
    int   exp_slices;
    int   exp_gap;
    int   exp_bp;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_start = 1'b0;
  logic               i_code_rate = 1'b0;
  logic               i_frame_valid = 1'b0;
  logic [FRAME_W-1:0] i_frame = '0;
  logic               i_last_frame = 1'b0;
  logic               i_dec_ready = 1'b1;
  logic               o_frame_ready;
  logic               o_en_s;
  logic [FRAME_W-1:0] o_frame;
  logic [PTR_W-1:0]   o_ptr;
  logic               o_ood;
  logic               o_busy;
  logic               o_done;
`ifdef SLICE_SCHED_STARVE_CNT_EN
  logic [15:0]        o_starve_cnt;
`endif

  int     checks = 0;
  int     errors = 0;
  slice_t sb[$];
  slice_t e;
  int     slices, gap_cyc, bp_cyc, rel_cnt, ood_cyc, done_cnt, done_cyc, cyc;
  int     cur_step = 4;
  int     cur_bp_ptr = -1;
  bit     mon_en = 1'b0;
  bit     first_seen, last_sent;
  vec_t   tbl[7];

  slice_sched #(
    .FRAME_W  (FRAME_W),
    .PTR_W    (PTR_W),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_code_rate  (i_code_rate),
    .i_frame_valid(i_frame_valid),
    .i_frame      (i_frame),
    .i_last_frame (i_last_frame),
    .o_frame_ready(o_frame_ready),
    .i_dec_ready  (i_dec_ready),
    .o_en_s       (o_en_s),
    .o_frame      (o_frame),
    .o_ptr        (o_ptr),
    .o_ood        (o_ood),
    .o_busy       (o_busy),
    .o_done       (o_done)
`ifdef SLICE_SCHED_STARVE_CNT_EN
    ,
    .o_starve_cnt (o_starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait expired after %0d cycles, expected event", name, TMO);
  endtask

  function automatic logic [FRAME_W-1:0] rand_frame();
    logic [287:0] t;
    for (int w = 0; w < 9; w++) t[w*32 +: 32] = $urandom;
    return t[FRAME_W-1:0];
  endfunction

  // Every accepted frame expands into its full slice sequence on the scoreboard.
  task automatic push_frame(input logic [FRAME_W-1:0] f, input bit last, input int step);
    slice_t s;
    for (int p = FRAME_W - 1; p >= step - 1; p -= step) begin
      s.ptr   = PTR_W'(p);
      s.frame = f;
      s.ood   = last && (p == step - 1);
      sb.push_back(s);
    end
  endtask

  task automatic send_frame(input bit last, input int step);
    logic [FRAME_W-1:0] f;
    int n;
    f = rand_frame();
    i_frame       = f;
    i_last_frame  = last;
    i_frame_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_frame_ready && n < TMO);
    if (!o_frame_ready) fail_timeout("frame_accept");
    else push_frame(f, last, step);
    @(posedge clk);
    #1;
    i_frame_valid = 1'b0;
    if (last) last_sent = 1'b1;
  endtask

  task automatic wait_ptr(input int target, input string name);
    int n;
    n = 0;
    while (o_ptr != PTR_W'(target) && n < TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (o_ptr != PTR_W'(target)) fail_timeout(name);
  endtask

  task automatic wait_rel(input int k);
    int n;
    n = 0;
    while (rel_cnt < k && n < TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (rel_cnt < k) fail_timeout("release_wait");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, o_frame_ready, 0);
    chk({tag, "_en"}, o_en_s, 0);
    chk({tag, "_ptr"}, o_ptr, FRAME_W - 1);
    chk({tag, "_ood"}, o_ood, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    checks++;
    if (o_frame !== '0) begin
      errors++;
      $display("[TB] FAIL %s_frame: got %h, expected 0", tag, o_frame);
    end
`ifdef SLICE_SCHED_STARVE_CNT_EN
    chk({tag, "_starve"}, o_starve_cnt, 0);
`endif
  endtask

  // Slice monitor: pops the scoreboard on every enabled slice and measures gaps and the drain timing.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      cyc++;
      if (o_en_s) begin
        slices++;
        first_seen = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra_slice: got slice at ptr %0d, expected none", o_ptr);
        end else begin
          e = sb.pop_front();
          chk("slice_ptr", o_ptr, e.ptr);
          chk("slice_ood", o_ood, e.ood);
          checks++;
          if (o_frame !== e.frame) begin
            errors++;
            $display("[TB] FAIL slice_frame: got %h, expected %h", o_frame, e.frame);
          end
        end
        if (o_ptr == PTR_W'(cur_step - 1)) rel_cnt++;
        if (o_ood) ood_cyc = cyc;
      end else begin
        chk("ood_without_en", o_ood, 0);
        if (first_seen && ood_cyc < 0 && o_busy) begin
          if (i_dec_ready) gap_cyc++;
          else bp_cyc++;
        end
      end
      if (!i_dec_ready && o_busy) begin
        chk("bp_en_low", o_en_s, 0);
        chk("bp_ptr_hold", o_ptr, cur_bp_ptr);
      end
      if (last_sent && o_busy) chk("ready_after_last", o_frame_ready, 0);
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    int n;
    sb.delete();
    slices = 0; gap_cyc = 0; bp_cyc = 0; rel_cnt = 0;
    ood_cyc = -1; done_cnt = 0; done_cyc = -1; cyc = 0;
    first_seen = 1'b0; last_sent = 1'b0;
    cur_step   = v.rate ? 6 : 4;
    cur_bp_ptr = v.bp_ptr;
    mon_en     = 1'b1;
    @(posedge clk);
    #1;
    i_code_rate = v.rate;
    i_start     = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    chk("ready_after_start", o_frame_ready, 1);
    chk("busy_after_start", o_busy, 1);
    fork
      begin
        for (int k = 0; k < v.nframes; k++) begin
          if (k > 0 && v.mode == M_GAP) begin
            wait_rel(k);
            repeat (v.gap - 1) begin
              @(posedge clk);
              #1;
            end
          end
          if (k > 0 && v.mode == M_SAME) wait_ptr(cur_step - 1, "same_edge_wait");
          send_frame(k == v.nframes - 1, cur_step);
        end
      end
      begin
        if (v.bp_ptr >= 0) begin
          wait_ptr(v.bp_ptr, "bp_wait");
          i_dec_ready = 1'b0;
          repeat (v.bp_len) begin
            @(posedge clk);
            #1;
          end
          i_dec_ready = 1'b1;
        end
      end
      begin
        if (v.poke_ptr >= 0) begin
          wait_ptr(v.poke_ptr, "poke_wait");
          i_start     = 1'b1;
          i_code_rate = ~v.rate;
          @(posedge clk);
          #1;
          i_start = 1'b0;
        end
      end
    join
    n = 0;
    while (done_cnt == 0 && n < TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt == 0) fail_timeout("done_wait");
  endtask

  task automatic checkOutput(input vec_t v);
    chk("slice_count", slices, v.exp_slices);
    chk("starve_gap", gap_cyc, v.exp_gap);
    chk("bp_cycles", bp_cyc, v.exp_bp);
    chk("done_pulses", done_cnt, 1);
    chk("ood_to_done", done_cyc - ood_cyc, DRAIN_CYC);
    chk("sb_empty", sb.size(), 0);
    chk("busy_after_done", o_busy, 0);
    chk("ready_after_done", o_frame_ready, 0);
`ifdef SLICE_SCHED_STARVE_CNT_EN
    chk("starve_cnt", o_starve_cnt, v.exp_gap);
`endif
  endtask

  initial begin
    //         rate  nfr mode    gap bp_ptr bp_len poke slices gap bp
    tbl[0] = '{1'b0, 2, M_B2B,  0,  -1,    0,     -1,  138,   0,  0};
    tbl[1] = '{1'b1, 1, M_B2B,  0,  -1,    0,     -1,  46,    0,  0};
    tbl[2] = '{1'b0, 2, M_GAP,  10, -1,    0,     -1,  138,   10, 0};
    tbl[3] = '{1'b0, 1, M_B2B,  0,  131,   5,     -1,  69,    0,  5};
    tbl[4] = '{1'b0, 2, M_B2B,  0,  -1,    0,     199, 138,   0,  0};
    tbl[5] = '{1'b0, 2, M_SAME, 0,  -1,    0,     -1,  138,   0,  0};
    tbl[6] = '{1'b1, 3, M_B2B,  0,  -1,    0,     -1,  138,   0,  0};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("in_reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("after_reset");

    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    // Asynchronous reset in the middle of a frame, then a clean run.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    i_code_rate = 1'b0;
    i_start     = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    send_frame(1'b1, 4);
    wait_ptr(99, "reset_ptr_wait");
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    last_sent = 1'b0;
    applyStimulus(tbl[0]);
    checkOutput(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
